// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for shift_rows_pipe: upstream valid/ready/data/inv,
// downstream valid/ready/data/inv, buffer occupancy and flush.
interface shift_rows_pipe_if #(
  parameter int NB = 4
) ();
  localparam int W = 32 * NB;

  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_inv;
  logic [1:0]   count;

  modport master (
    output flush, in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, out_inv, count
  );

  modport slave (
    input  flush, in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, out_inv, count
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Registered Rijndael ShiftRows (forward or inverse per transaction) for
// Nb = 4, 6 or 8, followed by a 2-entry FIFO holding the shifted state and its tag.
module shift_rows_pipe #(
  parameter int NB = 4
) (
  input logic              clk,
  input logic              rst_n,
  shift_rows_pipe_if.slave bus
);
  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  function automatic int row_shift(input int r);
    if (r == 0) return 0;
    if (NB == 8) return (r == 1) ? 1 : ((r == 2) ? 3 : 4);
    return r;
  endfunction

  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] shifted_data;

  // Pure byte wiring; byte k = 4c + r sits at [W-1-8k -: 8] (byte 0 is the MSB).
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int FWD_SRC = (c + row_shift(r)) % NB;
      localparam int INV_SRC = (c - row_shift(r) + NB) % NB;
      assign fwd_data[W-1-8*(4*c+r) -: 8] = bus.in_data[W-1-8*(4*FWD_SRC+r) -: 8];
      assign inv_data[W-1-8*(4*c+r) -: 8] = bus.in_data[W-1-8*(4*INV_SRC+r) -: 8];
    end
  end

  assign shifted_data = bus.in_inv ? inv_data : fwd_data;

  logic [W-1:0] mem_data [2];
  logic [1:0]   mem_inv;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;
  logic         accept;
  logic         pop;

  // Ready depends only on local state, so there is no combinational path from out_ready.
  assign bus.in_ready  = (count_q != 2'd2) && !bus.flush;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_inv   = mem_inv[rd_ptr];
  assign bus.count     = count_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_inv     <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count_q     <= 2'd0;
    end else if (bus.flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (accept) begin
        mem_data[wr_ptr] <= shifted_data;
        mem_inv[wr_ptr]  <= bus.in_inv;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
